// File: rtl/tbd_accel_ctrl_pkg.sv
// tbd_accel_ctrl_pkg
//
// Shared definitions for the tbd_accel sequencing controller:
//   - OBI subordinate request/response structs (32-bit address and data)
//   - register byte offsets and STATUS bit indices
//   - controller FSM state enum
//   - small helpers for byte-enable merging and saturating increment
package tbd_accel_ctrl_pkg;

    localparam int unsigned ObiIdWidth = 1;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           wdata;
        logic [ObiIdWidth-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]           rdata;
        logic [ObiIdWidth-1:0] rid;
        logic                  err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

    // Register byte offsets; only addr[4:2] is decoded.
    localparam logic [4:0] TbdCtrlOff    = 5'h00;
    localparam logic [4:0] TbdStatusOff  = 5'h04;
    localparam logic [4:0] TbdCyclesOff  = 5'h08;
    localparam logic [4:0] TbdTimeoutOff = 5'h0C;
    localparam logic [4:0] TbdRunsOff    = 5'h10;

    // STATUS bit indices
    localparam int unsigned StatusBusyBit    = 0;
    localparam int unsigned StatusDoneBit    = 1;
    localparam int unsigned StatusMatchBit   = 2;
    localparam int unsigned StatusTimeoutBit = 3;
    localparam int unsigned StatusOverrunBit = 4;

    // Read data returned for unmapped offsets 0x14-0x1C
    localparam logic [31:0] TbdErrData = 32'hBADC_AB1E;

    typedef enum logic [1:0] {
        TbdIdle  = 2'd0,
        TbdPulse = 2'd1,
        TbdWait  = 2'd2
    } tbd_ctrl_state_e;

    // Merge new_val into old_val byte by byte under the byte enables.
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/tbd_accel_ctrl.sv
// tbd_accel_ctrl
//
// OBI subordinate that sequences the tbd_accel pattern-match accelerator:
// software writes CTRL.START, the controller emits a one-cycle start pulse,
// then waits for done (or a watchdog timeout) and captures the results.
//
// Optional feature macro: TBD_ACCEL_CTRL_IRQ_EN
//   defined   -> irq_o port exists, CTRL.IRQ_EN is writable,
//                irq_o = IRQ_EN & DONE (registered level)
//   undefined -> no irq_o port, CTRL.IRQ_EN reads 0
//
// Ports:
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   obi_req_i     OBI request (addr, we, be, wdata, aid, req)
//   obi_rsp_o     OBI response (gnt = req, rvalid one cycle later)
//   accel_start_o one-cycle start pulse to the accelerator
//   accel_done_i  accelerator done (level or pulse)
//   accel_match_i match result, valid while accel_done_i is high
//   irq_o         interrupt level (only with TBD_ACCEL_CTRL_IRQ_EN)
module tbd_accel_ctrl
    import tbd_accel_ctrl_pkg::*;
#(
    parameter type         obi_req_t      = sbr_obi_req_t,
    parameter type         obi_rsp_t      = sbr_obi_rsp_t,
    parameter logic [31:0] DefaultTimeout = 32'h000F_FFFF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     accel_start_o,
    input  logic     accel_done_i,
    input  logic     accel_match_i
`ifdef TBD_ACCEL_CTRL_IRQ_EN
    ,
    output logic     irq_o
`endif
);

    localparam logic [2:0] CtrlIdx    = TbdCtrlOff[4:2];
    localparam logic [2:0] StatusIdx  = TbdStatusOff[4:2];
    localparam logic [2:0] CyclesIdx  = TbdCyclesOff[4:2];
    localparam logic [2:0] TimeoutIdx = TbdTimeoutOff[4:2];
    localparam logic [2:0] RunsIdx    = TbdRunsOff[4:2];

    tbd_ctrl_state_e state_q, state_d;

    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        tmo_q, tmo_d;
    logic        ovr_q, ovr_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] limit_q, limit_d;
    logic [31:0] runs_q, runs_d;

    logic                  rvalid_q;
    logic [ObiIdWidth-1:0] rid_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  irq_q;

    logic [2:0]  off;
    logic        wr;
    logic        be0;
    logic        start_wr;
    logic        busy;
    logic [31:0] rdata_mux;
    logic        err_mux;
    logic        unused_addr;

    assign off      = obi_req_i.a.addr[4:2];
    assign wr       = obi_req_i.req & obi_req_i.a.we;
    assign be0      = obi_req_i.a.be[0];
    assign start_wr = wr & be0 & (off == CtrlIdx) & obi_req_i.a.wdata[0];
    assign busy     = (state_q != TbdIdle);

    // Address bits outside the register window are intentionally ignored.
    assign unused_addr = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0]};

    // Read data mux: reflects register state at the grant edge.
    always_comb begin
        rdata_mux = '0;
        err_mux   = 1'b0;
        case (off)
            CtrlIdx:    rdata_mux[1] = irq_en_q;
            StatusIdx: begin
                rdata_mux[StatusBusyBit]    = busy;
                rdata_mux[StatusDoneBit]    = done_q;
                rdata_mux[StatusMatchBit]   = match_q;
                rdata_mux[StatusTimeoutBit] = tmo_q;
                rdata_mux[StatusOverrunBit] = ovr_q;
            end
            CyclesIdx:  rdata_mux = cycles_q;
            TimeoutIdx: rdata_mux = limit_q;
            RunsIdx:    rdata_mux = runs_q;
            default: begin
                rdata_mux = TbdErrData;
                err_mux   = 1'b1;
            end
        endcase
    end

    // Register writes first, then the FSM; FSM sets override a W1C in the
    // same cycle so a completion is never lost.
    always_comb begin
        state_d       = state_q;
        irq_en_d      = irq_en_q;
        done_d        = done_q;
        match_d       = match_q;
        tmo_d         = tmo_q;
        ovr_d         = ovr_q;
        cycles_d      = cycles_q;
        limit_d       = limit_q;
        runs_d        = runs_q;
        accel_start_o = 1'b0;

        if (wr) begin
            case (off)
`ifdef TBD_ACCEL_CTRL_IRQ_EN
                CtrlIdx: begin
                    if (be0) irq_en_d = obi_req_i.a.wdata[1];
                end
`endif
                StatusIdx: begin
                    if (be0) begin
                        if (obi_req_i.a.wdata[StatusDoneBit])    done_d = 1'b0;
                        if (obi_req_i.a.wdata[StatusTimeoutBit]) tmo_d  = 1'b0;
                        if (obi_req_i.a.wdata[StatusOverrunBit]) ovr_d  = 1'b0;
                    end
                end
                TimeoutIdx: limit_d = apply_be(limit_q, obi_req_i.a.wdata, obi_req_i.a.be);
                default: ;
            endcase
        end

        case (state_q)
            TbdIdle: begin
                if (start_wr) begin
                    state_d  = TbdPulse;
                    done_d   = 1'b0;
                    match_d  = 1'b0;
                    tmo_d    = 1'b0;
                    cycles_d = '0;
                end
            end
            TbdPulse: begin
                accel_start_o = 1'b1;
                cycles_d      = 32'd1;
                state_d       = TbdWait;
                if (start_wr) ovr_d = 1'b1;
            end
            TbdWait: begin
                if (start_wr) ovr_d = 1'b1;
                if (accel_done_i) begin
                    done_d  = 1'b1;
                    match_d = accel_match_i;
                    runs_d  = runs_q + 32'd1;
                    state_d = TbdIdle;
                end else if ((limit_q != '0) && (cycles_q == limit_q)) begin
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = TbdIdle;
                end else begin
                    cycles_d = sat_inc(cycles_q);
                end
            end
            default: state_d = TbdIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= TbdIdle;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            tmo_q    <= 1'b0;
            ovr_q    <= 1'b0;
            cycles_q <= '0;
            limit_q  <= DefaultTimeout;
            runs_q   <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            match_q  <= match_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
            cycles_q <= cycles_d;
            limit_q  <= limit_d;
            runs_q   <= runs_d;
            // irq follows the post-edge register values, so it moves in the
            // same cycle STATUS.DONE does.
            irq_q    <= irq_en_d & done_d;
            rvalid_q <= obi_req_i.req;
            if (obi_req_i.req) begin
                rid_q   <= obi_req_i.a.aid;
                rdata_q <= rdata_mux;
                err_q   <= err_mux;
            end
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = rid_q;
        obi_rsp_o.r.err   = err_q;
    end

`ifdef TBD_ACCEL_CTRL_IRQ_EN
    assign irq_o = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_tbd_accel_ctrl.sv
// tb_tbd_accel_ctrl
//
// Bench for tbd_accel_ctrl: a register-access vector table, directed runs
// (done, timeout, overrun, interrupt, reset mid-run) and randomized runs
// checked against a register-level model of the controller.
// Honours TBD_ACCEL_CTRL_IRQ_EN the same way the design does.
module tb_tbd_accel_ctrl;
    import tbd_accel_ctrl_pkg::*;

    localparam logic [31:0] A_CTRL    = 32'h00;
    localparam logic [31:0] A_STATUS  = 32'h04;
    localparam logic [31:0] A_CYCLES  = 32'h08;
    localparam logic [31:0] A_TIMEOUT = 32'h0C;
    localparam logic [31:0] A_RUNS    = 32'h10;
    localparam logic [31:0] DEF_TMO   = 32'h000F_FFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    sbr_obi_req_t req;
    sbr_obi_rsp_t rsp;
    logic         start;
    logic         acc_done = 1'b0;
    logic         man_done;
    logic         acc_match = 1'b0;
    logic         done_in;
    logic         irq;

    assign done_in = acc_done | man_done;

    always #5 clk = ~clk;

    tbd_accel_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .obi_req_i     (req),
        .obi_rsp_o     (rsp),
        .accel_start_o (start),
        .accel_done_i  (done_in),
        .accel_match_i (acc_match)
`ifdef TBD_ACCEL_CTRL_IRQ_EN
        ,
        .irq_o         (irq)
`endif
    );

`ifndef TBD_ACCEL_CTRL_IRQ_EN
    assign irq = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Accelerator model: drives done+match 'acc_delay' cycles after the
    // start pulse (0 = never). Also counts start pulses and irq rise time.
    int acc_delay   = 0;
    bit acc_match_v = 1'b0;
    bit armed       = 1'b0;
    int cnt         = 0;
    int pulses      = 0;
    int cyc         = 0;
    int done_cyc    = -1;
    int irq_cyc     = -1;
    bit irq_seen    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        acc_done  = 1'b0;
        acc_match = 1'b0;
        if (start) begin
            pulses++;
            armed = 1'b1;
            cnt   = 0;
        end else if (armed) begin
            cnt++;
            if (acc_delay != 0 && cnt == acc_delay) begin
                acc_done  = 1'b1;
                acc_match = acc_match_v;
                armed     = 1'b0;
                done_cyc  = cyc;
            end
        end
        if (irq && !irq_seen) begin
            irq_seen = 1'b1;
            irq_cyc  = cyc;
        end
    end

    // Register model
    bit          m_irq_en;
    bit          m_done, m_match, m_tmo, m_ovr;
    logic [31:0] m_cycles, m_timeout, m_runs;

    function automatic logic [31:0] m_status();
        return {27'd0, m_ovr, m_tmo, m_match, m_done, 1'b0};
    endfunction

    task automatic model_reset();
        m_irq_en  = 1'b0;
        m_done    = 1'b0;
        m_match   = 1'b0;
        m_tmo     = 1'b0;
        m_ovr     = 1'b0;
        m_cycles  = '0;
        m_timeout = DEF_TMO;
        m_runs    = '0;
    endtask

    function automatic bit ctrl_irq_bit(input logic [31:0] wdata);
`ifdef TBD_ACCEL_CTRL_IRQ_EN
        return wdata[1];
`else
        return 1'b0;
`endif
    endfunction

    task automatic bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        logic aid;
        @(posedge clk);
        #1;
        aid         = 1'($urandom);
        req.req     = 1'b1;
        req.a.addr  = addr;
        req.a.we    = we;
        req.a.be    = be;
        req.a.wdata = wdata;
        req.a.aid   = aid;
        #1;
        chk("gnt", rsp.gnt, 1);
        chk("rvalid_before_grant", rsp.rvalid, 0);
        @(posedge clk);
        #1;
        req.req = 1'b0;
        chk("rvalid_after_grant", rsp.rvalid, 1);
        chk("rid", rsp.r.rid, aid);
        rdata = rsp.r.rdata;
        err   = rsp.r.err;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        bus(addr, 1'b0, 4'hF, 32'h0, d, e);
        chk(name, d, exp);
        chk({name, "_err"}, e, 0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        bus(addr, 1'b1, 4'hF, data, d, e);
        chk("write_err", e, 0);
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        logic        e;
        int          n;
        n = 0;
        do begin
            bus(A_STATUS, 1'b0, 4'hF, 32'h0, d, e);
            n++;
        end while (d[0] && n < 200);
        chk("idle_within_budget", d[0], 0);
    endtask

    // One complete run. Expected results come straight from the register
    // rules: a run ends at d cycles after the pulse on done, or at lim
    // cycles on timeout if the limit is hit strictly first.
    task automatic do_run(input int d, input bit m, input logic [31:0] lim, input bit overrun);
        int p0;
        wr(A_TIMEOUT, lim);
        m_timeout   = lim;
        acc_delay   = d;
        acc_match_v = m;
        p0          = pulses;
        wr(A_CTRL, {30'd0, m_irq_en, 1'b1});
        chk("start_high_after_grant", start, 1);
        if (overrun) begin
            wr(A_CTRL, {30'd0, m_irq_en, 1'b1});
            m_ovr = 1'b1;
        end
        wait_idle();
        m_tmo = 1'b0;
        if (lim != 0 && (d == 0 || int'(lim) < d)) begin
            m_done   = 1'b1;
            m_tmo    = 1'b1;
            m_match  = 1'b0;
            m_cycles = lim;
        end else begin
            m_done   = 1'b1;
            m_match  = m;
            m_cycles = d;
            m_runs   = m_runs + 1;
        end
        rd_chk("run_status", A_STATUS, m_status());
        rd_chk("run_cycles", A_CYCLES, m_cycles);
        rd_chk("run_runs", A_RUNS, m_runs);
        chk("run_start_pulses", pulses - p0, 1);
        chk("run_irq_level", irq, m_irq_en & m_done);
        // Let a late done from a timed-out run arrive while IDLE.
        repeat (d + 3) @(posedge clk);
        acc_delay = 0;
        rd_chk("post_run_status", A_STATUS, m_status());
        rd_chk("post_run_runs", A_RUNS, m_runs);
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] exp_ctrl;

        req      = '0;
        man_done = 1'b0;
        rst_n    = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_start", start, 0);
        chk("reset_rvalid", rsp.rvalid, 0);
        chk("reset_irq", irq, 0);
        rst_n = 1'b1;

        // Register access table
`ifdef TBD_ACCEL_CTRL_IRQ_EN
        exp_ctrl = 32'h2;
`else
        exp_ctrl = 32'h0;
`endif
        tbl.push_back('{"rst_status",   A_STATUS,  1'b0, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0});
        tbl.push_back('{"rst_cycles",   A_CYCLES,  1'b0, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0});
        tbl.push_back('{"rst_timeout",  A_TIMEOUT, 1'b0, 4'hF, 32'h0,        1'b1, DEF_TMO,      1'b0});
        tbl.push_back('{"rst_runs",     A_RUNS,    1'b0, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0});
        tbl.push_back('{"rst_ctrl",     A_CTRL,    1'b0, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0});
        tbl.push_back('{"rd_err_18",    32'h18,    1'b0, 4'hF, 32'h0,        1'b1, 32'hBADCAB1E, 1'b1});
        tbl.push_back('{"rd_err_14",    32'h14,    1'b0, 4'hF, 32'h0,        1'b1, 32'hBADCAB1E, 1'b1});
        tbl.push_back('{"rd_err_1c",    32'h1C,    1'b0, 4'hF, 32'h0,        1'b1, 32'hBADCAB1E, 1'b1});
        tbl.push_back('{"wr_tmo_lo",    A_TIMEOUT, 1'b1, 4'h3, 32'h12345678, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{"tmo_be_lo",    A_TIMEOUT, 1'b0, 4'hF, 32'h0,        1'b1, 32'h000F5678, 1'b0});
        tbl.push_back('{"wr_tmo_hi",    A_TIMEOUT, 1'b1, 4'hC, 32'hABCD0000, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{"tmo_be_hi",    A_TIMEOUT, 1'b0, 4'hF, 32'h0,        1'b1, 32'hABCD5678, 1'b0});
        tbl.push_back('{"wr_err_14",    32'h14,    1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 32'hBADCAB1E, 1'b1});
        tbl.push_back('{"tmo_after_err",A_TIMEOUT, 1'b0, 4'hF, 32'h0,        1'b1, 32'hABCD5678, 1'b0});
        tbl.push_back('{"wr_ctrl_nobe", A_CTRL,    1'b1, 4'h0, 32'h3,        1'b0, 32'h0,        1'b0});
        tbl.push_back('{"status_nobe",  A_STATUS,  1'b0, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0});
        tbl.push_back('{"wr_ctrl_irq",  A_CTRL,    1'b1, 4'hF, 32'h2,        1'b0, 32'h0,        1'b0});
        tbl.push_back('{"ctrl_irq_en",  A_CTRL,    1'b0, 4'hF, 32'h0,        1'b1, exp_ctrl,     1'b0});
        tbl.push_back('{"wr_ctrl_zero", A_CTRL,    1'b1, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
        tbl.push_back('{"ctrl_alias",   32'h20,    1'b0, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0});
        tbl.push_back('{"wr_status_w1c",A_STATUS,  1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{"status_w1c",   A_STATUS,  1'b0, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0});

        foreach (tbl[i]) begin
            bus(tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wdata, d, e);
            if (tbl[i].chk_rd) chk(tbl[i].name, d, tbl[i].exp_rdata);
            chk({tbl[i].name, "_err"}, e, tbl[i].exp_err);
        end
        m_timeout = 32'hABCD5678;
        chk("table_no_start_pulse", pulses, 0);

        // Normal completion: done+match 10 cycles after the pulse
        do_run(10, 1'b1, 32'd0, 1'b0);
        // Watchdog: limit 5, accelerator never answers
        do_run(0, 1'b0, 32'd5, 1'b0);
        // Done and timeout in the same cycle: done wins
        do_run(7, 1'b1, 32'd7, 1'b0);

        // START while busy sets OVERRUN but does not restart
        do_run(15, 1'b0, 32'd0, 1'b1);
        wr(A_STATUS, 32'h10);
        m_ovr = 1'b0;
        rd_chk("overrun_cleared", A_STATUS, m_status());

        // done while IDLE is ignored
        @(posedge clk);
        #1;
        man_done = 1'b1;
        @(posedge clk);
        #1;
        man_done = 1'b0;
        rd_chk("idle_done_status", A_STATUS, m_status());
        rd_chk("idle_done_runs", A_RUNS, m_runs);
        rd_chk("idle_done_cycles", A_CYCLES, m_cycles);

`ifdef TBD_ACCEL_CTRL_IRQ_EN
        // Interrupt rises one cycle after done, drops after DONE is cleared
        wr(A_CTRL, 32'h2);
        m_irq_en = 1'b1;
        irq_seen = 1'b0;
        do_run(6, 1'b1, 32'd0, 1'b0);
        chk("irq_rise_latency", irq_cyc - done_cyc, 1);
        chk("irq_high_before_clear", irq, 1);
        wr(A_STATUS, 32'h02);
        m_done = 1'b0;
        chk("irq_low_after_clear", irq, 0);
        wr(A_CTRL, 32'h0);
        m_irq_en = 1'b0;
`endif

        // Randomized runs
        for (int k = 0; k < 10; k++) begin
            int          rd_d;
            bit          rd_m;
            logic [31:0] rd_lim;
            logic [31:0] cw;
            rd_d   = $urandom_range(1, 20);
            rd_m   = 1'($urandom);
            rd_lim = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 22));
            cw     = {30'd0, 1'($urandom), 1'b0};
            wr(A_CTRL, cw);
            m_irq_en = ctrl_irq_bit(cw);
            do_run(rd_d, rd_m, rd_lim, 1'b0);
        end

        // Reset in the middle of a run
        wr(A_CTRL, 32'h0);
        m_irq_en = 1'b0;
        wr(A_TIMEOUT, 32'd0);
        acc_delay = 0;
        wr(A_CTRL, 32'h1);
        repeat (3) @(posedge clk);
        rd_chk("busy_in_wait", A_STATUS, {27'd0, m_ovr, 3'b000, 1'b1});
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        req.req     = 1'b1;
        req.a.addr  = A_STATUS;
        req.a.we    = 1'b0;
        @(posedge clk);
        #1;
        req.req = 1'b0;
        chk("midrst_start", start, 0);
        chk("midrst_rvalid", rsp.rvalid, 0);
        chk("midrst_irq", irq, 0);
        chk("midrst_rdata", rsp.r.rdata, 0);
        chk("midrst_err", rsp.r.err, 0);
        rst_n = 1'b1;
        model_reset();
        rd_chk("midrst_status", A_STATUS, m_status());
        rd_chk("midrst_cycles", A_CYCLES, m_cycles);
        rd_chk("midrst_timeout", A_TIMEOUT, m_timeout);
        rd_chk("midrst_runs", A_RUNS, m_runs);
        rd_chk("midrst_ctrl", A_CTRL, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
